// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flow controller.
//   FWD_*      : operand forwarding mux selects driven on forward_a / forward_b
//   pipe_state_e : controller FSM states (normal flow / waiting on a multi-cycle EX op)
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG     = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_WB      = 2'b01;  // WB-stage write data
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;  // MEM-stage ALU result
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;  // MEM-stage load data (combinational dmem)

  typedef enum logic {
    ST_RUN,
    ST_MC_WAIT
  } pipe_state_e;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one EX source operand.
//   rs_i                      : source register read by the EX instruction
//   rd_mem_i, regwrite_mem_i  : destination / write enable of the MEM instruction
//   mem_read_mem_i            : MEM instruction is a load
//   rd_wb_i, regwrite_wb_i    : destination / write enable of the WB instruction
//   fwd_o                     : mux select (see pipe_ctrl_pkg FWD_*)
// The MEM stage holds the younger result, so it wins over WB. x0 is never forwarded.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] rd_mem_i,
  input  logic            regwrite_mem_i,
  input  logic            mem_read_mem_i,
  input  logic [RA_W-1:0] rd_wb_i,
  input  logic            regwrite_wb_i,
  output logic [1:0]      fwd_o
);

  always_comb begin
    fwd_o = FWD_REG;
    if (regwrite_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i)) begin
      fwd_o = mem_read_mem_i ? FWD_MEM_LD : FWD_MEM_ALU;
    end else if (regwrite_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard and flow controller for the 5-stage RISC-V pipeline.
// Inputs : register addresses / write enables of ID, EX, MEM, WB; load flags for EX and MEM;
//          multi-cycle op flag and done strobe; resolved taken-branch strobe.
// Outputs: PC / IF-ID / ID-EX write enables, IF-ID / ID-EX / EX-MEM flushes, operand forward
//          selects, multi-cycle start/abort pulses and saturating perf counters.
// Priority of actions: reset > taken branch > multi-cycle freeze > load-use bubble > normal.
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W           = 5,
  parameter int unsigned BRANCH_STAGE   = 2,  // 1: branch resolves in EX, 2: in MEM
  parameter int unsigned LOAD_USE_STALL = 1,  // 0: rely on MEM load-data forwarding instead
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs1_id,
  input  logic [RA_W-1:0]  rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [RA_W-1:0]  rs1_ex,
  input  logic [RA_W-1:0]  rs2_ex,
  input  logic [RA_W-1:0]  rd_ex,
  input  logic [RA_W-1:0]  rd_mem,
  input  logic [RA_W-1:0]  rd_wb,
  input  logic             regwrite_ex,
  input  logic             regwrite_mem,
  input  logic             regwrite_wb,
  input  logic             mem_read_ex,
  input  logic             mem_read_mem,
  input  logic             mc_op_ex,
  input  logic             mc_done,
  input  logic             branch_taken,
  output logic             pc_write_enable,
  output logic             if_id_write_enable,
  output logic             id_ex_write_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mc_start,
  output logic             mc_abort,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam bit BranchInMem = (BRANCH_STAGE == 2);
  localparam bit LoadUseOn   = (LOAD_USE_STALL != 0);

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             load_use;

  fwd_select #(
    .RA_W(RA_W)
  ) u_fwd_a (
    .rs_i          (rs1_ex),
    .rd_mem_i      (rd_mem),
    .regwrite_mem_i(regwrite_mem),
    .mem_read_mem_i(mem_read_mem),
    .rd_wb_i       (rd_wb),
    .regwrite_wb_i (regwrite_wb),
    .fwd_o         (fwd_a_raw)
  );

  fwd_select #(
    .RA_W(RA_W)
  ) u_fwd_b (
    .rs_i          (rs2_ex),
    .rd_mem_i      (rd_mem),
    .regwrite_mem_i(regwrite_mem),
    .mem_read_mem_i(mem_read_mem),
    .rd_wb_i       (rd_wb),
    .regwrite_wb_i (regwrite_wb),
    .fwd_o         (fwd_b_raw)
  );

  assign forward_a = reset ? FWD_REG : fwd_a_raw;
  assign forward_b = reset ? FWD_REG : fwd_b_raw;

  always_comb begin
    load_use = LoadUseOn && mem_read_ex && regwrite_ex && (rd_ex != '0) &&
               ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));
  end

  // Flow control and FSM next state.
  always_comb begin
    state_d            = state_q;
    pc_write_enable    = 1'b1;
    if_id_write_enable = 1'b1;
    id_ex_write_enable = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    ex_mem_flush       = 1'b0;
    mc_start           = 1'b0;
    mc_abort           = 1'b0;

    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_RUN;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      // A MEM-stage branch is older than the EX instruction, so EX must be squashed too.
      ex_mem_flush = BranchInMem;
      if (state_q == ST_MC_WAIT) begin
        if (BranchInMem) begin
          mc_abort = 1'b1;
          state_d  = ST_RUN;
        end else if (mc_done) begin
          state_d = ST_RUN;
        end
      end
    end else if (state_q == ST_RUN && mc_op_ex) begin
      mc_start           = 1'b1;
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
      id_ex_write_enable = 1'b0;
      ex_mem_flush       = 1'b1;
      state_d            = ST_MC_WAIT;
    end else if (state_q == ST_MC_WAIT) begin
      if (mc_done) begin
        // Result is captured into EX/MEM this cycle; pipeline resumes.
        state_d = ST_RUN;
      end else begin
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        id_ex_write_enable = 1'b0;
        ex_mem_flush       = 1'b1;
      end
    end else if (load_use) begin
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
      id_ex_flush        = 1'b1;
    end
  end

  // Saturating performance counters.
  always_comb begin
    cycle_count_d = cycle_count_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
    if (!pc_write_enable && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (branch_taken && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cycle_count_q <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
